// File: rtl/hit_pkg.sv
// Shared types and sizes for the bullet/meteor collision scanner.
package hit_pkg;

  localparam int COORD_W     = 10;
  localparam int SCORE_W     = 16;
  localparam int MAX_METEORS = 16;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HIT,
    DONE
  } state_e;

endpackage

// File: rtl/overlap_check.sv
// Axis-aligned box overlap between two centred squares, evaluated one bit
// wider than the coordinates so differences and reach never wrap.
module overlap_check
  import hit_pkg::*;
(
  input  logic [COORD_W-1:0] ax_i,
  input  logic [COORD_W-1:0] ay_i,
  input  logic [COORD_W-1:0] as_i,
  input  logic [COORD_W-1:0] bx_i,
  input  logic [COORD_W-1:0] by_i,
  input  logic [COORD_W-1:0] bs_i,
  output logic               overlap_o
);

  logic [COORD_W:0] dx, dy, reach;

  always_comb begin
    dx = (ax_i >= bx_i) ? ({1'b0, ax_i} - {1'b0, bx_i}) : ({1'b0, bx_i} - {1'b0, ax_i});
    dy = (ay_i >= by_i) ? ({1'b0, ay_i} - {1'b0, by_i}) : ({1'b0, by_i} - {1'b0, ay_i});
    reach = {1'b0, as_i} + {1'b0, bs_i};
    overlap_o = (dx < reach) && (dy < reach);
  end

endmodule

// File: rtl/bullet_hit_detect.sv
// Per-frame bullet-vs-meteor scanner: one slot per Clk, lowest hit slot wins.
// Optional HIT_SCORE_EN macro enables the saturating hit counter on score.
module bullet_hit_detect
  import hit_pkg::*;
#(
  parameter int NUM_METEORS = 8
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           frame_clk,
  input  logic                           bullet_active,
  input  logic [COORD_W-1:0]             bullet_X,
  input  logic [COORD_W-1:0]             bullet_Y,
  input  logic [COORD_W-1:0]             bullet_size,
  input  logic [COORD_W*NUM_METEORS-1:0] meteor_X,
  input  logic [COORD_W*NUM_METEORS-1:0] meteor_Y,
  input  logic [COORD_W*NUM_METEORS-1:0] meteor_S,
  input  logic [NUM_METEORS-1:0]         meteor_alive,
  output logic                           bullet_hit,
  output logic                           meteor_kill,
  output logic [3:0]                     meteor_hit_idx,
  output logic [SCORE_W-1:0]             score
);

  if (NUM_METEORS < 1 || NUM_METEORS > MAX_METEORS) begin : gBadParam
    $error("NUM_METEORS out of range");
  end

  localparam logic [3:0] LAST_SLOT = 4'(NUM_METEORS - 1);

  state_e             state_q;
  logic [2:0]         sync_q;
  logic [3:0]         slot_q;
  logic               bulletActive_q;
  logic [COORD_W-1:0] bulletX_q, bulletY_q, bulletS_q;
  logic               hit_q, kill_q;
  logic [3:0]         hitIdx_q;

  logic               frameTick, slotOverlap, slotHit, slotAlive;
  logic [COORD_W-1:0] slotX, slotY, slotS;

  assign frameTick = sync_q[1] & ~sync_q[2];

  // Slot data is muxed live from the packed inputs; only the bullet is frozen.
  always_comb begin
    slotX     = '0;
    slotY     = '0;
    slotS     = '0;
    slotAlive = 1'b0;
    for (int i = 0; i < NUM_METEORS; i++) begin
      if (slot_q == 4'(i)) begin
        slotX     = meteor_X[i*COORD_W +: COORD_W];
        slotY     = meteor_Y[i*COORD_W +: COORD_W];
        slotS     = meteor_S[i*COORD_W +: COORD_W];
        slotAlive = meteor_alive[i];
      end
    end
  end

  overlap_check uOverlap (
    .ax_i      (bulletX_q),
    .ay_i      (bulletY_q),
    .as_i      (bulletS_q),
    .bx_i      (slotX),
    .by_i      (slotY),
    .bs_i      (slotS),
    .overlap_o (slotOverlap)
  );

  assign slotHit = slotAlive & slotOverlap;

  // Kill and hit are registered on leaving HIT, so a tick during HIT suppresses them.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= IDLE;
      sync_q         <= '0;
      slot_q         <= '0;
      bulletActive_q <= 1'b0;
      bulletX_q      <= '0;
      bulletY_q      <= '0;
      bulletS_q      <= '0;
      hit_q          <= 1'b0;
      kill_q         <= 1'b0;
      hitIdx_q       <= '0;
    end else begin
      sync_q <= {sync_q[1:0], frame_clk};
      kill_q <= 1'b0;
      if (frameTick) begin
        hit_q          <= 1'b0;
        bulletActive_q <= bullet_active;
        bulletX_q      <= bullet_X;
        bulletY_q      <= bullet_Y;
        bulletS_q      <= bullet_size;
        slot_q         <= '0;
        state_q        <= SCAN;
      end else begin
        case (state_q)
          SCAN: begin
            if (!bulletActive_q) begin
              state_q <= DONE;
            end else if (slotHit) begin
              state_q <= HIT;
            end else if (slot_q == LAST_SLOT) begin
              state_q <= DONE;
            end else begin
              slot_q <= slot_q + 4'd1;
            end
          end
          HIT: begin
            hit_q    <= 1'b1;
            kill_q   <= 1'b1;
            hitIdx_q <= slot_q;
            state_q  <= DONE;
          end
          default: ;
        endcase
      end
    end
  end

  assign bullet_hit     = hit_q;
  assign meteor_kill    = kill_q;
  assign meteor_hit_idx = hitIdx_q;

`ifdef HIT_SCORE_EN
  logic [SCORE_W-1:0] score_q, score_d;

  always_comb begin
    score_d = score_q;
    if (state_q == HIT && !frameTick && score_q != {SCORE_W{1'b1}}) begin
      score_d = score_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

endmodule

// File: tb/tb_bullet_hit_detect.sv
// Directed self-checking bench for bullet_hit_detect (default NUM_METEORS = 8).
module tb_bullet_hit_detect;

  localparam int N = 8;

  logic            Clk = 1'b0;
  logic            Reset_n;
  logic            frame_clk;
  logic            bullet_active;
  logic [9:0]      bullet_X, bullet_Y, bullet_size;
  logic [10*N-1:0] meteor_X, meteor_Y, meteor_S;
  logic [N-1:0]    meteor_alive;
  logic            bullet_hit, meteor_kill;
  logic [3:0]      meteor_hit_idx;
  logic [15:0]     score;

  int checks = 0;
  int errors = 0;
  int killCount = 0;
  int hits = 0;
  int k0;

  bullet_hit_detect #(.NUM_METEORS(N)) dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .frame_clk      (frame_clk),
    .bullet_active  (bullet_active),
    .bullet_X       (bullet_X),
    .bullet_Y       (bullet_Y),
    .bullet_size    (bullet_size),
    .meteor_X       (meteor_X),
    .meteor_Y       (meteor_Y),
    .meteor_S       (meteor_S),
    .meteor_alive   (meteor_alive),
    .bullet_hit     (bullet_hit),
    .meteor_kill    (meteor_kill),
    .meteor_hit_idx (meteor_hit_idx),
    .score          (score)
  );

  always #10 Clk = ~Clk;

  always @(posedge Clk) begin
    if (meteor_kill === 1'b1) killCount++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic act, input logic [9:0] x, input logic [9:0] y, input logic [9:0] s);
    bullet_active = act;
    bullet_X      = x;
    bullet_Y      = y;
    bullet_size   = s;
  endtask

  task automatic clearMeteors();
    meteor_X     = '0;
    meteor_Y     = '0;
    meteor_S     = '0;
    meteor_alive = '0;
  endtask

  task automatic setMeteor(input int i, input logic [9:0] x, input logic [9:0] y, input logic [9:0] s);
    meteor_X[i*10 +: 10] = x;
    meteor_Y[i*10 +: 10] = y;
    meteor_S[i*10 +: 10] = s;
    meteor_alive[i]      = 1'b1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Called at a negedge; returns at the negedge just before the edge that consumes the tick.
  task automatic startFrame();
    frame_clk = 1'b1;
    cyc(2);
    frame_clk = 1'b0;
  endtask

  function automatic logic [15:0] expScore();
`ifdef HIT_SCORE_EN
    return 16'(hits);
`else
    return 16'd0;
`endif
  endfunction

  initial begin
    Reset_n   = 1'b0;
    frame_clk = 1'b0;
    applyStimulus(1'b0, 10'd0, 10'd0, 10'd0);
    clearMeteors();
    cyc(1);
    checkOutput("reset_hit", 16'(bullet_hit), 16'd0);
    checkOutput("reset_kill", 16'(meteor_kill), 16'd0);
    checkOutput("reset_idx", 16'(meteor_hit_idx), 16'd0);
    checkOutput("reset_score", score, 16'd0);
    Reset_n = 1'b1;
    applyStimulus(1'b1, 10'd100, 10'd200, 10'd3);
    setMeteor(0, 10'd104, 10'd203, 10'd8);
    cyc(12);
    checkOutput("idle_hit", 16'(bullet_hit), 16'd0);
    checkOutput("idle_kills", 16'(killCount), 16'd0);

    // Single hit on slot 2; dead overlapping slot 1 ignored; bullet moved after snapshot.
    clearMeteors();
    setMeteor(0, 10'd300, 10'd300, 10'd2);
    setMeteor(1, 10'd100, 10'd200, 10'd5);
    meteor_alive[1] = 1'b0;
    setMeteor(2, 10'd104, 10'd203, 10'd8);
    startFrame();
    cyc(1);
    bullet_X = 10'd500;
    cyc(3);
    checkOutput("hit1_pre_kill", 16'(meteor_kill), 16'd0);
    checkOutput("hit1_pre_hit", 16'(bullet_hit), 16'd0);
    cyc(1);
    hits++;
    checkOutput("hit1_kill", 16'(meteor_kill), 16'd1);
    checkOutput("hit1_idx", 16'(meteor_hit_idx), 16'd2);
    checkOutput("hit1_hit", 16'(bullet_hit), 16'd1);
    checkOutput("hit1_score", score, expScore());
    cyc(1);
    checkOutput("hit1_kill_pulse", 16'(meteor_kill), 16'd0);
    cyc(5);
    checkOutput("hit1_hold", 16'(bullet_hit), 16'd1);
    checkOutput("hit1_kills", 16'(killCount), 16'd1);

    // Inactive bullet: straight to DONE, no kill.
    applyStimulus(1'b0, 10'd100, 10'd200, 10'd3);
    k0 = killCount;
    startFrame();
    cyc(1);
    checkOutput("inact_clear", 16'(bullet_hit), 16'd0);
    cyc(1);
    checkOutput("inact_hit", 16'(bullet_hit), 16'd0);
    cyc(10);
    checkOutput("inact_kills", 16'(killCount - k0), 16'd0);
    checkOutput("inact_score", score, expScore());

    // Slots 1 and 5 both overlap: lowest index wins, one kill.
    clearMeteors();
    applyStimulus(1'b1, 10'd100, 10'd200, 10'd3);
    setMeteor(1, 10'd98, 10'd198, 10'd2);
    setMeteor(5, 10'd100, 10'd200, 10'd1);
    k0 = killCount;
    startFrame();
    cyc(3);
    checkOutput("multi_pre_kill", 16'(meteor_kill), 16'd0);
    cyc(1);
    hits++;
    checkOutput("multi_kill", 16'(meteor_kill), 16'd1);
    checkOutput("multi_idx", 16'(meteor_hit_idx), 16'd1);
    checkOutput("multi_hit", 16'(bullet_hit), 16'd1);
    cyc(10);
    checkOutput("multi_kills", 16'(killCount - k0), 16'd1);
    checkOutput("multi_score", score, expScore());

    // Boundary: dx == bs+ms misses, dx == bs+ms-1 hits.
    clearMeteors();
    setMeteor(0, 10'd111, 10'd200, 10'd8);
    k0 = killCount;
    startFrame();
    cyc(10);
    checkOutput("dx11_hit", 16'(bullet_hit), 16'd0);
    checkOutput("dx11_kills", 16'(killCount - k0), 16'd0);
    setMeteor(0, 10'd110, 10'd200, 10'd8);
    startFrame();
    cyc(3);
    hits++;
    checkOutput("dx10_kill", 16'(meteor_kill), 16'd1);
    checkOutput("dx10_idx", 16'(meteor_hit_idx), 16'd0);
    checkOutput("dx10_hit", 16'(bullet_hit), 16'd1);
    setMeteor(0, 10'd100, 10'd211, 10'd8);
    cyc(2);
    k0 = killCount;
    startFrame();
    cyc(10);
    checkOutput("dy11_hit", 16'(bullet_hit), 16'd0);
    checkOutput("dy11_kills", 16'(killCount - k0), 16'd0);

    // Far-apart X near the coordinate limits must not alias into a hit.
    applyStimulus(1'b1, 10'd5, 10'd200, 10'd3);
    setMeteor(0, 10'd1020, 10'd200, 10'd8);
    k0 = killCount;
    startFrame();
    cyc(10);
    checkOutput("wrap_hit", 16'(bullet_hit), 16'd0);
    checkOutput("wrap_kills", 16'(killCount - k0), 16'd0);

    // Second tick mid-SCAN restarts; hit in last slot lands N+1 cycles later.
    applyStimulus(1'b1, 10'd100, 10'd200, 10'd3);
    clearMeteors();
    setMeteor(7, 10'd100, 10'd200, 10'd4);
    k0 = killCount;
    startFrame();
    cyc(2);
    startFrame();
    cyc(8);
    checkOutput("abort_early_kill", 16'(meteor_kill), 16'd0);
    checkOutput("abort_early_hit", 16'(bullet_hit), 16'd0);
    cyc(1);
    checkOutput("abort_hitstate_kill", 16'(meteor_kill), 16'd0);
    cyc(1);
    hits++;
    checkOutput("abort_kill", 16'(meteor_kill), 16'd1);
    checkOutput("abort_idx", 16'(meteor_hit_idx), 16'd7);
    checkOutput("abort_hit", 16'(bullet_hit), 16'd1);
    cyc(3);
    checkOutput("abort_kills", 16'(killCount - k0), 16'd1);

    // Hit on slot 3, then reset mid-SCAN of the next frame.
    setMeteor(3, 10'd100, 10'd200, 10'd4);
    startFrame();
    cyc(6);
    hits++;
    checkOutput("pre_rst_idx", 16'(meteor_hit_idx), 16'd3);
    checkOutput("pre_rst_score", score, expScore());
    startFrame();
    cyc(3);
    Reset_n = 1'b0;
    #1;
    hits = 0;
    checkOutput("rst_hit", 16'(bullet_hit), 16'd0);
    checkOutput("rst_kill", 16'(meteor_kill), 16'd0);
    checkOutput("rst_idx", 16'(meteor_hit_idx), 16'd0);
    checkOutput("rst_score", score, 16'd0);
    cyc(1);
    Reset_n = 1'b1;
    k0 = killCount;
    cyc(12);
    checkOutput("post_rst_idle_hit", 16'(bullet_hit), 16'd0);
    checkOutput("post_rst_idle_kills", 16'(killCount - k0), 16'd0);

    for (int f = 0; f < 3; f++) begin
      startFrame();
      cyc(6);
      hits++;
      checkOutput("loop_kill", 16'(meteor_kill), 16'd1);
      checkOutput("loop_idx", 16'(meteor_hit_idx), 16'd3);
      checkOutput("loop_score", score, expScore());
      cyc(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
